beat_meter: RTL and testbench

Tempo/period measurement block: the receiving end of the beat clocks produced by the team's clock dividers. It samples an asynchronous, slow beat signal (a divider output such as the 0.75 s beat, or a debounced tap key) and reports the interval between accepted rising edges in `clk` cycles. It also emits a one-cycle strobe per accepted beat and flags loss of beat. Consumers are the playback sequencer and tempo display logic.

---
 rtl/beat_meter.sv | 91 +++++++++
 tb/tb_beat_meter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/beat_meter.sv
// beat_meter: measures the spacing of accepted rising beat edges in clk cycles; `define BEAT_METER_AVG_EN for 4-sample averaging
module beat_meter #(
  parameter int CNT_W      = 32,
  parameter int MIN_PERIOD = 5_000_000,
  parameter int TIMEOUT    = 200_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beat_in,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             beat_pulse,
  output logic             timeout
);
  typedef enum logic {IDLE, MEASURE} state_t;
  localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  state_t state, state_nxt;
  logic sync1, sync2, sync3;
  logic rise, accept, expire, flush, measure;
  logic [CNT_W-1:0] cnt, cnt_inc, cnt_nxt, period_nxt;
  logic valid_nxt, pulse_nxt, tmo_nxt;
  assign rise = sync2 & ~sync3;
  assign cnt_inc = cnt + 1'b1;
  assign accept = rise & (state == IDLE | cnt_inc >= MIN_P);
  assign expire = state == MEASURE & ~accept & cnt_inc == TMO;
  assign flush = clear | expire;
  assign measure = accept & ~clear & state == MEASURE;
  // two-flop synchronizer plus edge-history flop; clear leaves these alone
  always_ff @(posedge clk or negedge rst)
    if (!rst) {sync1, sync2, sync3} <= '0;
    else {sync1, sync2, sync3} <= {beat_in, sync1, sync2};
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nxt;
  // next state: clear and timeout fall back to IDLE, any accepted edge starts a measurement
  always_comb state_nxt = flush ? IDLE : accept ? MEASURE : state;
`ifdef BEAT_METER_AVG_EN
  logic [CNT_W-1:0] hist [4];
  logic [CNT_W+1:0] sum, sum_nxt;
  logic [2:0] fill;
  logic full_nxt;
  assign sum_nxt = sum - {2'b00, hist[3]} + {2'b00, cnt_inc};
  assign full_nxt = fill >= 3'd3;
  // history of the last four raw measurements, hist[0] newest; empty slots hold zero
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hist <= '{default: '0};
      sum <= '0;
      fill <= '0;
    end else if (flush) begin
      hist <= '{default: '0};
      sum <= '0;
      fill <= '0;
    end else if (measure) begin
      hist <= '{cnt_inc, hist[0], hist[1], hist[2]};
      sum <= sum_nxt;
      fill <= full_nxt ? 3'd4 : fill + 3'd1;
    end
`endif
  // registered output and counter next values
  always_comb begin
    cnt_nxt = (flush | accept | state == IDLE) ? '0 : cnt_inc;
    pulse_nxt = accept & ~clear;
    tmo_nxt = clear ? 1'b0 : expire ? 1'b1 : accept ? 1'b0 : timeout;
`ifdef BEAT_METER_AVG_EN
    period_nxt = flush ? '0 : (measure & full_nxt) ? CNT_W'(sum_nxt >> 2) : period;
    valid_nxt = ~flush & (period_valid | (measure & full_nxt));
`else
    period_nxt = flush ? '0 : measure ? cnt_inc : period;
    valid_nxt = ~flush & (period_valid | measure);
`endif
  end
  // counter and output registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      period <= '0;
      period_valid <= 1'b0;
      beat_pulse <= 1'b0;
      timeout <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      period <= period_nxt;
      period_valid <= valid_nxt;
      beat_pulse <= pulse_nxt;
      timeout <= tmo_nxt;
    end
endmodule

// File: tb/tb_beat_meter.sv
// tb_beat_meter: randomized scoreboard bench for beat_meter against an edge-timing reference model
module tb_beat_meter;
  localparam int CNT_W = 32;
  localparam int MIN_P = 4;
  localparam int TMO = 100;
  logic clk = 0, rst = 1, beat_in = 0, clear = 0;
  logic [CNT_W-1:0] period;
  logic period_valid, beat_pulse, timeout;
  int cyc = 0, checks = 0, failures = 0;
  typedef struct {int p; bit pulse; logic [31:0] per; bit val; bit tmo;} ev_t;
  ev_t q[$];
  bit idle = 1, val = 0, tmo = 0;
  int t_last = 0;
  logic [31:0] per = 0;
  int hist[$];
  bit l0 = 0, l1 = 0, l2 = 0, l3 = 0;

  beat_meter #(.CNT_W(CNT_W), .MIN_PERIOD(MIN_P), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .beat_in(beat_in), .clear(clear),
    .period(period), .period_valid(period_valid), .beat_pulse(beat_pulse), .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int p, input bit pulse);
    ev_t e;
    e.p = p; e.pulse = pulse; e.per = per; e.val = val; e.tmo = tmo;
    q.push_back(e);
  endtask

  // Inputs driven now are seen by the posedge p; a rise driven at cycle m is detected at posedge m+3.
  task automatic model_step();
    int p, m;
    bit ed;
    p = cyc + 1;
    {l3, l2, l1, l0} = {l2, l1, l0, beat_in};
    ed = l2 & ~l3;
    if (clear) begin
      idle = 1; per = 0; val = 0; tmo = 0; hist.delete();
      push(p, 0);
    end else if (ed && (idle || p - t_last >= MIN_P)) begin
      if (!idle) begin
        m = p - t_last;
`ifdef BEAT_METER_AVG_EN
        hist.push_back(m);
        if (hist.size() > 4) void'(hist.pop_front());
        if (hist.size() == 4) begin
          per = 32'((hist[0] + hist[1] + hist[2] + hist[3]) / 4);
          val = 1;
        end
`else
        per = 32'(m);
        val = 1;
`endif
      end
      idle = 0; tmo = 0; t_last = p;
      push(p, 1);
    end else if (!idle && p - t_last == TMO) begin
      idle = 1; tmo = 1; per = 0; val = 0; hist.delete();
      push(p, 0);
    end
  endtask

  task automatic tick(input bit b, input bit c);
    @(negedge clk);
    beat_in = b;
    clear = c;
    model_step();
  endtask

  task automatic wave(input int gap, input int width, input bit rc);
    for (int i = 0; i < gap; i++) tick(i < width, rc && $urandom_range(0, 40) == 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; beat_in = 0; clear = 0;
    {l3, l2, l1, l0} = '0;
    idle = 1; per = 0; val = 0; tmo = 0; hist.delete();
    push(cyc + 1, 0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst = 1;
    model_step();
  endtask

  // monitor: pops the expected event for this cycle, otherwise outputs must hold the last event's values
  initial begin
    ev_t h, e;
    bit ep;
    h.p = 0; h.pulse = 0; h.per = 0; h.val = 0; h.tmo = 0;
    forever begin
      @(posedge clk);
      #1;
      ep = 0;
      if (q.size() != 0 && q[0].p == cyc) begin
        e = q.pop_front();
        h = e;
        ep = e.pulse;
      end
      chk("beat_pulse", 32'(beat_pulse), 32'(ep));
      chk("period", period, h.per);
      chk("period_valid", 32'(period_valid), 32'(h.val));
      chk("timeout", 32'(timeout), 32'(h.tmo));
    end
  end

  initial begin
    int gap;
    #1 rst = 0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst = 1;
    model_step();
    repeat (50) tick(0, 0);
    repeat (6) wave(20, 10, 0);
    chk("square_period", period, 20);
    chk("square_valid", 32'(period_valid), 1);
    tick(1, 0); tick(0, 0); tick(1, 0);
    repeat (17) tick(0, 0);
    repeat (2) wave(20, 10, 0);
    chk("glitch_period", period, 20);
    repeat (130) tick(0, 0);
    chk("lost_timeout", 32'(timeout), 1);
    chk("lost_period", period, 0);
    chk("lost_valid", 32'(period_valid), 0);
    wave(20, 10, 0);
    chk("relock_timeout", 32'(timeout), 0);
    chk("relock_valid", 32'(period_valid), 0);
    repeat (2) wave(20, 10, 0);
    chk("relock_period", period, 20);
    tick(1, 0); tick(1, 0); tick(1, 1);
    repeat (17) tick(0, 0);
    chk("clear_period", period, 0);
    chk("clear_valid", 32'(period_valid), 0);
    repeat (3) wave(20, 10, 0);
    tick(0, 1);
    repeat (30) tick(0, 0);
    wave(20, 5, 0); wave(20, 5, 0); wave(24, 5, 0); wave(24, 5, 0); wave(24, 5, 0);
`ifdef BEAT_METER_AVG_EN
    chk("avg_period", period, 22);
`else
    chk("avg_period", period, 24);
`endif
    chk("avg_valid", 32'(period_valid), 1);
    for (int i = 0; i < 80; i++) begin
      if (i == 40) do_reset();
      gap = $urandom_range(2, 110);
      wave(gap, $urandom_range(1, gap - 1), 1);
    end
    repeat (150) tick(0, 0);
    @(negedge clk);
    chk("events_drained", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
